sample_writer: RTL and testbench

- Write-side stage of the capture FIFO in the oscilloscope datapath.
- Takes ADC samples, arms on request, and detects a level-crossing trigger.
- After the trigger it writes a fixed-length burst into the FIFO memory and advances the binary write pointer seen by the read-pointer stage.
- Detects FIFO full against the read pointer returned from the read side. Full drops samples and sets a sticky overflow flag.

---
 rtl/sample_writer_pkg.sv | 27 ++
 rtl/sample_writer_trig_detect.sv | 39 +++
 rtl/sample_writer.sv | 104 ++++++++++
 tb/tb_sample_writer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sample_writer_pkg.sv
// Shared definitions for the capture FIFO: state encoding and pointer helpers
// used by both the write and read pointer stages.
package sample_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int unsigned PTR_MAX_W = 16;
  typedef logic [PTR_MAX_W-1:0] ptr_t;

  // Binary +1 wrapping at 2^aw; pointers narrower than PTR_MAX_W are zero-extended.
  function automatic ptr_t ptr_inc(input ptr_t p, input int unsigned aw);
    ptr_t mask;
    mask = (aw >= PTR_MAX_W) ? '1 : ((ptr_t'(1) << aw) - ptr_t'(1));
    return (p + ptr_t'(1)) & mask;
  endfunction

  // One slot stays unused so equal pointers always mean empty.
  function automatic logic fifo_full(input ptr_t wp, input ptr_t rp, input int unsigned aw);
    return ptr_inc(wp, aw) == rp;
  endfunction

endpackage

// File: rtl/sample_writer_trig_detect.sv
// Level-crossing trigger: remembers the previous armed sample and flags a crossing
// between it and the current one.
module sample_writer_trig_detect #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] sample,
  input  logic                 valid,
  input  logic                 track,
  input  logic                 clear,
  input  logic [DATA_SIZE-1:0] level,
  input  logic                 rising,
  output logic                 hit
);

  logic [DATA_SIZE-1:0] prev;
  logic                 prev_valid;
  logic                 crossing;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      prev_valid <= 1'b0;
    end else if (track && valid) begin
      prev       <= sample;
      prev_valid <= 1'b1;
    end
  end

  always_comb begin
    crossing = rising ? (prev < level && sample >= level)
                      : (prev > level && sample <= level);
    hit      = valid && prev_valid && crossing;
  end

endmodule

// File: rtl/sample_writer.sv
// Write side of the capture FIFO: arms, waits for a level-crossing trigger, then
// writes a fixed-length burst and publishes the committed write pointer.
module sample_writer
  import sample_writer_pkg::*;
#(
  parameter int ADDR_SIZE   = 8,
  parameter int DATA_SIZE   = 8,
  parameter int CAPTURE_LEN = 200
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_SIZE-1:0] sample_i,
  input  logic                 sample_valid_i,
  input  logic                 arm_i,
  input  logic [DATA_SIZE-1:0] trig_level_i,
  input  logic                 trig_rising_i,
  input  logic [ADDR_SIZE-1:0] rr_ptr_2_i,
  output logic                 we_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic [DATA_SIZE-1:0] wdata_o,
  output logic [ADDR_SIZE-1:0] ptr_o,
  output logic                 fifo_full_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overflow_o
);

  state_t               state, state_nxt;
  logic [ADDR_SIZE-1:0] wa, wa_inc;
  logic [15:0]          count, count_nxt;
  logic                 trig_hit, accept, rearm;

  // arm restarts the search in ARMED, so it blocks a trigger in the same cycle
  assign rearm = arm_i && (state != ST_CAPTURE);

  sample_writer_trig_detect #(.DATA_SIZE(DATA_SIZE)) u_trig (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .sample (sample_i),
    .valid  (sample_valid_i),
    .track  (state == ST_ARMED),
    .clear  (rearm),
    .level  (trig_level_i),
    .rising (trig_rising_i),
    .hit    (trig_hit)
  );

  assign fifo_full_o = fifo_full(ptr_t'(wa), ptr_t'(rr_ptr_2_i), ADDR_SIZE);
  assign wa_inc      = ADDR_SIZE'(ptr_inc(ptr_t'(wa), ADDR_SIZE));
  assign busy_o      = (state == ST_ARMED) || (state == ST_CAPTURE);
  assign done_o      = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    accept    = 1'b0;
    case (state)
      ST_IDLE: if (arm_i) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (!arm_i && trig_hit) begin
          accept    = 1'b1;
          count_nxt = 16'd1;
          state_nxt = (CAPTURE_LEN == 1) ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (sample_valid_i) begin
          accept    = 1'b1;
          count_nxt = count + 16'd1;
          if (count_nxt == 16'(CAPTURE_LEN)) state_nxt = ST_DONE;
        end
      end
      ST_DONE: if (arm_i) state_nxt = ST_ARMED;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      count      <= '0;
      wa         <= '0;
      ptr_o      <= '0;
      addr_o     <= '0;
      wdata_o    <= '0;
      we_o       <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      ptr_o <= wa;
      we_o  <= accept && !fifo_full_o;
      if (accept && !fifo_full_o) begin
        addr_o  <= wa;
        wdata_o <= sample_i;
        wa      <= wa_inc;
      end
      // dropped samples still count toward the burst, keeping length fixed in time
      if (rearm)                      overflow_o <= 1'b0;
      else if (accept && fifo_full_o) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sample_writer.sv
// Scoreboard bench for sample_writer with a 16-deep FIFO and 5-sample bursts.
module tb_sample_writer;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int CL = 5;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [DW-1:0] sample_i = '0;
  logic          sample_valid_i = 1'b0;
  logic          arm_i = 1'b0;
  logic [DW-1:0] trig_level_i = 8'h80;
  logic          trig_rising_i = 1'b1;
  logic [AW-1:0] rr_ptr_2_i = '0;
  logic          we_o, fifo_full_o, busy_o, done_o, overflow_o;
  logic [AW-1:0] addr_o, ptr_o;
  logic [DW-1:0] wdata_o;

  sample_writer #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .CAPTURE_LEN(CL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .arm_i(arm_i), .trig_level_i(trig_level_i), .trig_rising_i(trig_rising_i),
    .rr_ptr_2_i(rr_ptr_2_i), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .ptr_o(ptr_o), .fifo_full_o(fifo_full_o), .busy_o(busy_o), .done_o(done_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sbq[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [AW-1:0] m_wa = '0;
  logic          m_ovf = 1'b0;
  logic          ptr_chk = 1'b0;
  logic [AW-1:0] exp_ptr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Every write pulse must match the oldest expected write; ptr_o follows a cycle later.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (ptr_chk) begin
        check("ptr_lag", 32'(ptr_o), 32'(exp_ptr));
        ptr_chk = 1'b0;
      end
      if (we_o) begin
        if (sbq.size() == 0) check("we_spurious", 32'(we_o), 32'd0);
        else begin
          exp_t e;
          e = sbq.pop_front();
          check("wr_cycle", 32'(cyc), 32'(e.cyc));
          check("wr_addr", 32'(addr_o), 32'(e.addr));
          check("wr_data", 32'(wdata_o), 32'(e.data));
          exp_ptr = e.addr + 4'd1;
          ptr_chk = 1'b1;
        end
      end
    end
  end

  // Drive one valid sample; acc says whether the reference expects it accepted.
  task automatic send(input logic [DW-1:0] s, input bit acc);
    exp_t e;
    @(negedge clk_i);
    sample_i = s;
    sample_valid_i = 1'b1;
    if (acc) begin
      if (m_wa + 4'd1 == rr_ptr_2_i) m_ovf = 1'b1;
      else begin
        e.cyc = cyc + 1; e.addr = m_wa; e.data = s;
        sbq.push_back(e);
        m_wa = m_wa + 4'd1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      sample_valid_i = 1'b0;
    end
  endtask

  task automatic arm();
    @(negedge clk_i);
    sample_valid_i = 1'b0;
    arm_i = 1'b1;
    @(negedge clk_i);
    arm_i = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic check_end(input string tag);
    idle(3);
    check({tag, "_done"}, 32'(done_o), 32'd1);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_ptr"}, 32'(ptr_o), 32'(m_wa));
    check({tag, "_ovf"}, 32'(overflow_o), 32'(m_ovf));
    check({tag, "_full"}, 32'(fifo_full_o), 32'(m_wa + 4'd1 == rr_ptr_2_i));
    check({tag, "_pending"}, 32'(sbq.size()), 32'd0);
  endtask

  task automatic std_capture();
    arm();
    send(8'h10, 0);
    send(8'h90, 1);
    for (int i = 1; i < CL; i++) send(8'(8'hA0 + i), 1);
    check_end("std");
  endtask

  initial begin
    #12;
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_ptr", 32'(ptr_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    idle(2);

    // rising capture: trigger on 90, five writes, E0 arrives after DONE
    arm();
    check("armed_busy", 32'(busy_o), 32'd1);
    send(8'h10, 0); send(8'h70, 0);
    send(8'h90, 1); send(8'hA0, 1); send(8'hB0, 1); send(8'hC0, 1); send(8'hD0, 1);
    send(8'hE0, 0);
    check_end("rise");

    // first sample after arm never triggers, even above level
    arm();
    send(8'h90, 0); send(8'h95, 0);
    idle(1);
    check("nofalse_we", 32'(we_o), 32'd0);
    check("nofalse_busy", 32'(busy_o), 32'd1);
    send(8'h20, 0);
    send(8'h85, 1);
    for (int i = 0; i < CL - 1; i++) send(8'(8'h40 + i), 1);
    check_end("late");

    // falling trigger fills the FIFO up to one free slot
    trig_rising_i = 1'b0;
    arm();
    send(8'h90, 0); send(8'h70, 1);
    for (int i = 0; i < CL - 1; i++) send(8'(8'h60 - i), 1);
    check_end("fall");
    check("full_at_15", 32'(fifo_full_o), 32'd1);

    // whole burst dropped: overflow, no writes, pointer stays
    trig_rising_i = 1'b1;
    arm();
    send(8'h10, 0); send(8'h90, 1);
    for (int i = 0; i < CL - 1; i++) send(8'(8'h91 + i), 1);
    check_end("ovf");
    check("ovf_set", 32'(overflow_o), 32'd1);

    // re-arm clears overflow/done; reset mid-capture abandons the burst
    rr_ptr_2_i = 4'd8;
    arm();
    check("rearm_ovf", 32'(overflow_o), 32'd0);
    check("rearm_done", 32'(done_o), 32'd0);
    send(8'h10, 0); send(8'h90, 1); send(8'h91, 1);
    idle(2);
    rst_i = 1'b0;
    #1;
    check("mid_rst_we", 32'(we_o), 32'd0);
    check("mid_rst_addr", 32'(addr_o), 32'd0);
    check("mid_rst_wdata", 32'(wdata_o), 32'd0);
    check("mid_rst_ptr", 32'(ptr_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_done", 32'(done_o), 32'd0);
    check("mid_rst_ovf", 32'(overflow_o), 32'd0);
    m_wa = '0;
    ptr_chk = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    rr_ptr_2_i = 4'd0;
    for (int k = 0; k < 3; k++) std_capture();

    // wrap from address 15 through 0 with the reader at 10
    rr_ptr_2_i = 4'd10;
    std_capture();
    check("wrap_ptr", 32'(ptr_o), 32'd4);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
